button_conditioner: RTL

//   Conditions raw push-button and slide-switch pins for mux_control, which sits directly downstream.

---
 rtl/button_conditioner.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Conditions raw push-button and slide-switch pins for mux_control.
//   Every channel (N_BUTTONS buttons plus one switch) gets a 2-flop
//   synchroniser and an independent STABLE/PENDING debounce FSM with its own
//   counter. Buttons also get a registered one-cycle press pulse on each
//   accepted 0->1 transition.
//
//   Optional feature (macro BTN_AUTOREPEAT_EN):
//     defined   - each held button emits extra press pulses REPEAT_DELAY cycles
//                 after acceptance and then every REPEAT_PERIOD cycles.
//     undefined - exactly one pulse per accepted press.
//
// Ports
//   clock        in   system clock, all state on rising edge
//   reset        in   asynchronous active-low reset
//   raw_buttons  in   [N_BUTTONS] asynchronous button pins, 1 = pressed
//   raw_switch   in   asynchronous slide-switch pin
//   buttons      out  [N_BUTTONS] debounced button levels (registered)
//   button_press out  [N_BUTTONS] one-cycle press pulses (registered)
//   switch       out  debounced switch level (registered)
// ---------------------------------------------------------------------------
module button_conditioner #(
  parameter int unsigned N_BUTTONS       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] raw_buttons,
  input  logic                 raw_switch,
  output logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] button_press,
  output logic                 switch
);

  // Channel N_BUTTONS is the switch; all lower channels are buttons.
  localparam int unsigned N_CH = N_BUTTONS + 1;

  // Last count value before a differing input is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || N_BUTTONS < 1)
  begin : g_bad_param
    $error("button_conditioner: N_BUTTONS, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD must be >= 1");
  end
  if (CNT_W < 32 && (DEBOUNCE_CYCLES - 1) >= (32'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("button_conditioner: CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  logic [N_CH-1:0]      raw_ch;
  logic [N_CH-1:0]      sync1_q, sync1_d;
  logic [N_CH-1:0]      sync2_q, sync2_d;
  state_e               state_q [N_CH];
  state_e               state_d [N_CH];
  logic [CNT_W-1:0]     cnt_q   [N_CH];
  logic [CNT_W-1:0]     cnt_d   [N_CH];
  logic [N_CH-1:0]      stable_q, stable_d;
  logic [N_BUTTONS-1:0] press_q, press_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                      : REPEAT_PERIOD;
  localparam int unsigned HOLD_W     = $clog2(REPEAT_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);

  // hold counts cycles since the last pulse; phase=1 once the first repeat fired.
  logic [HOLD_W-1:0]    hold_q  [N_BUTTONS];
  logic [HOLD_W-1:0]    hold_d  [N_BUTTONS];
  logic [N_BUTTONS-1:0] phase_q, phase_d;
`endif

  assign raw_ch = {raw_switch, raw_buttons};

  // Synchroniser next values: plain two-stage shift, no logic between stages.
  always_comb begin
    sync1_d = raw_ch;
    sync2_d = sync1_q;
  end

  // State register for all channels.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
`ifdef BTN_AUTOREPEAT_EN
      phase_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        hold_q[i] <= '0;
      end
`endif
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
`ifdef BTN_AUTOREPEAT_EN
      phase_q <= phase_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        hold_q[i] <= hold_d[i];
      end
`endif
    end
  end

  // Debounce next-state: a level is accepted after DEBOUNCE_CYCLES
  // consecutive differing samples; any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != stable_q[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // Single-cycle window: accept immediately, PENDING never held.
              stable_d[i] = sync2_q[i];
            end else begin
              state_d[i] = ST_PENDING;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        ST_PENDING: begin
          if (sync2_q[i] == stable_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = ST_STABLE;
            cnt_d[i]    = '0;
            stable_d[i] = sync2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Press pulse generation; registered so it lines up with the new level.
  always_comb begin
    press_d = stable_d[N_BUTTONS-1:0] & ~stable_q[N_BUTTONS-1:0];
`ifdef BTN_AUTOREPEAT_EN
    phase_d = phase_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      hold_d[i] = hold_q[i];
      if (!stable_d[i] || !stable_q[i]) begin
        // Released, idle, or just accepted: timing restarts from here.
        hold_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
        if (hold_d[i] == (phase_q[i] ? HOLD_PERIOD : HOLD_DELAY)) begin
          press_d[i] = 1'b1;
          hold_d[i]  = '0;
          phase_d[i] = 1'b1;
        end
      end
    end
`endif
  end

  assign buttons      = stable_q[N_BUTTONS-1:0];
  assign switch       = stable_q[N_BUTTONS];
  assign button_press = press_q;

endmodule
